ascon_ti_masker: RTL and testbench
==================================

ASCON_TI_MASKER -- requirements
Module: ascon_ti_masker

Interface
REQ-001 SHALL have parameter WORDS, default 5, giving the number of 64-bit words per Ascon state frame.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports seed_valid input 1, seed_a input 64, seed_b input 64, seed_ready output 1  PRNG reseed handshake.
REQ-005 SHALL have ports in_valid input 1, in_data input 64, in_ready output 1  unmasked state-word input stream.
REQ-006 SHALL have ports out_valid output 1, out_s0 output 64, out_s1 output 64, out_s2 output 64, out_idx output 3, out_last output 1, out_ready input 1  3-share output stream for the TI S-box layer.
REQ-007 SHALL have port flush input 1  synchronous abort of the current frame.

Function
REQ-008 SHALL hold two 64-bit PRNG registers ra, rb, each advanced by xorshift64: x^=x<<13; x^=x>>7; x^=x<<17.
REQ-009 On an input transfer (in_valid&&in_ready), the output register SHALL load s1=ra, s2=rb, s0=in_data^ra^rb, all using the pre-advance ra/rb; ra and rb SHALL then both advance once in the same cycle.
REQ-010 Latency SHALL be 1 cycle: out_valid rises the cycle after the input transfer; the output register is a single entry.
REQ-011 in_ready SHALL equal (!out_valid || out_ready) && !(seed_valid && seed_ready) && !flush.
REQ-012 Output SHALL hold s0/s1/s2/idx/last stable while out_valid && !out_ready; out_valid clears on out_ready unless a new input transfer occurs in the same cycle (back-to-back at 1 word/cycle).
REQ-013 A word counter cnt (0..WORDS-1) SHALL increment on each input transfer, wrap WORDS-1 -> 0; out_idx = cnt at capture; out_last = (out_idx==WORDS-1).
REQ-014 FSM SHALL have states IDLE (cnt==0) and FRAME (cnt!=0); IDLE->FRAME on input transfer when WORDS>1; FRAME->IDLE on transfer of word WORDS-1 or on flush.
REQ-015 seed_ready SHALL equal (state==IDLE) && !out_valid && !flush; on seed transfer ra<=seed_a, rb<=seed_b, with no PRNG advance that cycle.
REQ-016 A seed value of zero SHALL be replaced by that register's reset constant (xorshift lock-up avoidance), independently for a and b.
REQ-017 Seed transfer and input transfer SHALL never occur in the same cycle (seed has priority via REQ-011).
REQ-018 flush SHALL, in the same clock edge, clear cnt to 0, state to IDLE, and out_valid to 0; ra/rb retain their values; flush takes priority over all transfers.
REQ-019 Share words SHALL satisfy s0^s1^s2 == in_data for every transferred word.

Reset
REQ-020 On rst_n low, asynchronously: out_valid=0, out_s0/s1/s2=0, out_idx=0, out_last=0, cnt=0, state=IDLE, ra=64'h0123456789ABCDEF, rb=64'hFEDCBA9876543210.
REQ-021 seed_ready SHALL be 1 and in_ready SHALL be 1 in the first cycle after reset release (with seed_valid=0, flush=0).
REQ-022 Reset asserted mid-frame SHALL discard the pending output and frame position; no output transfer is produced from pre-reset data.

Verification
REQ-023 Seed a=1, b=2; send in_data=0xFF then 0x0 with out_ready=1 -> word0: s1=0x1, s2=0x2, s0=0xFC; word1: s1=0x40822041, s2=0x81044082, s0=0xC18660C3.
REQ-024 Stream 5 words back-to-back with out_ready=1 -> 5 consecutive out_valid cycles, out_idx 0..4, out_last only on idx 4, s0^s1^s2 equals each input.
REQ-025 Hold out_ready=0 after one word -> in_ready=0, outputs stable for 10 cycles; release -> transfer once, in_ready=1 same cycle.
REQ-026 Assert seed_valid at cnt=2 -> seed_ready=0, seed not loaded; after word idx 4 drains, seed_ready=1 and load occurs; seed a=0 -> ra becomes 0x0123456789ABCDEF.
REQ-027 flush after word idx 1 with out_valid=1 -> next cycle out_valid=0, next accepted word has out_idx=0; ra/rb continue from pre-flush values.
REQ-028 rst_n low at cnt=3 with out_valid=1 -> out_valid=0 immediately, ra/rb at reset constants, next word out_idx=0.

Source files
------------

// File: rtl/ascon_ti_masker.sv
// Splits unmasked Ascon state words into three XOR shares (s0^s1^s2 == data)
// for a threshold-implementation S-box layer, using two xorshift64 PRNGs.
module ascon_ti_masker #(
  parameter int WORDS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_valid,
  input  logic [63:0] seed_a,
  input  logic [63:0] seed_b,
  output logic        seed_ready,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_s0,
  output logic [63:0] out_s1,
  output logic [63:0] out_s2,
  output logic [2:0]  out_idx,
  output logic        out_last,
  input  logic        out_ready,
  input  logic        flush,
  output logic [0:0]  o_dbg_state
);

  localparam logic [63:0] RA_RST   = 64'h0123456789ABCDEF;
  localparam logic [63:0] RB_RST   = 64'hFEDCBA9876543210;
  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_FRAME = 1'b1;
  localparam logic [2:0]  LAST_IDX = 3'(WORDS - 1);

  logic [63:0] r_ra;
  logic [63:0] r_rb;
  logic [63:0] r_s0;
  logic [63:0] r_s1;
  logic [63:0] r_s2;
  logic [2:0]  r_cnt;
  logic [2:0]  r_idx;
  logic        r_last;
  logic        r_out_valid;
  logic [0:0]  r_state;

  logic        w_seed_ready;
  logic        w_in_ready;
  logic        w_seed_xfer;
  logic        w_in_xfer;
  logic [2:0]  w_cnt_nxt;
  logic [63:0] w_seed_a;
  logic [63:0] w_seed_b;

  function automatic logic [63:0] f_xorshift(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // ready never depends on the same channel's valid. flush blocks every
  // transfer, and a pending seed transfer blocks input transfers.
  assign w_seed_ready = (r_state == ST_IDLE) && !r_out_valid && !flush;
  assign w_in_ready   = (!r_out_valid || out_ready) && !(seed_valid && w_seed_ready) && !flush;
  assign w_seed_xfer  = seed_valid && w_seed_ready;
  assign w_in_xfer    = in_valid && w_in_ready;
  assign w_cnt_nxt    = (r_cnt == LAST_IDX) ? 3'd0 : r_cnt + 3'd1;

  // A zero seed would lock xorshift at zero forever.
  assign w_seed_a = (seed_a == 64'd0) ? RA_RST : seed_a;
  assign w_seed_b = (seed_b == 64'd0) ? RB_RST : seed_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 3'd0;
      r_state <= ST_IDLE;
    end else if (flush) begin
      r_cnt   <= 3'd0;
      r_state <= ST_IDLE;
    end else if (w_in_xfer) begin
      r_cnt   <= w_cnt_nxt;
      r_state <= (w_cnt_nxt != 3'd0) ? ST_FRAME : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra <= RA_RST;
      r_rb <= RB_RST;
    end else if (flush) begin
      r_ra <= r_ra;
      r_rb <= r_rb;
    end else if (w_seed_xfer) begin
      r_ra <= w_seed_a;
      r_rb <= w_seed_b;
    end else if (w_in_xfer) begin
      r_ra <= f_xorshift(r_ra);
      r_rb <= f_xorshift(r_rb);
    end
  end

  // Single-entry output register; shares use the PRNG values before advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_s0        <= 64'd0;
      r_s1        <= 64'd0;
      r_s2        <= 64'd0;
      r_idx       <= 3'd0;
      r_last      <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_s0        <= in_data ^ r_ra ^ r_rb;
      r_s1        <= r_ra;
      r_s2        <= r_rb;
      r_idx       <= r_cnt;
      r_last      <= (r_cnt == LAST_IDX);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign seed_ready  = w_seed_ready;
  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_s0      = r_s0;
  assign out_s1      = r_s1;
  assign out_s2      = r_s2;
  assign out_idx     = r_idx;
  assign out_last    = r_last;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ascon_ti_masker.sv
// Bench for ascon_ti_masker: directed scenarios plus random traffic, all
// outputs compared at the falling edge against a queue-based reference.
module tb_ascon_ti_masker;

  localparam int          WORDS  = 5;
  localparam logic [63:0] RA_RST = 64'h0123456789ABCDEF;
  localparam logic [63:0] RB_RST = 64'hFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_valid;
  logic [63:0] seed_a;
  logic [63:0] seed_b;
  logic        seed_ready;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_s0;
  logic [63:0] out_s1;
  logic [63:0] out_s2;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_ready;
  logic        flush;
  logic [0:0]  o_dbg_state;

  ascon_ti_masker #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .seed_valid(seed_valid), .seed_a(seed_a), .seed_b(seed_b), .seed_ready(seed_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2),
    .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready),
    .flush(flush), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: PRNG words, frame position, expected-output queue
  // entry layout: {data[259:196], idx[195:193], last[192], s0, s1, s2}
  logic [63:0]  m_ra = RA_RST;
  logic [63:0]  m_rb = RB_RST;
  int           m_cnt = 0;
  logic [259:0] exp_q[$];
  logic [259:0] m_head;
  logic         m_ov;
  logic         m_sr;
  logic         m_ir;

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // scoreboard: inputs are stable at the falling edge, so the model decides
  // here what the next rising edge will do
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
      m_ra  = RA_RST;
      m_rb  = RB_RST;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk64("rst_out_s0", out_s0, 64'd0);
      chk64("rst_out_idx", 64'(out_idx), 64'd0);
    end else begin
      m_ov = (exp_q.size() != 0);
      chk1("out_valid", out_valid, m_ov);
      if (m_ov) begin
        m_head = exp_q[0];
        chk64("out_s0", out_s0, m_head[191:128]);
        chk64("out_s1", out_s1, m_head[127:64]);
        chk64("out_s2", out_s2, m_head[63:0]);
        chk64("out_idx", 64'(out_idx), 64'(m_head[195:193]));
        chk1("out_last", out_last, m_head[192]);
        chk64("share_xor", out_s0 ^ out_s1 ^ out_s2, m_head[259:196]);
      end
      m_sr = (m_cnt == 0) && !m_ov && !flush;
      m_ir = (!m_ov || out_ready) && !(seed_valid && m_sr) && !flush;
      chk1("seed_ready", seed_ready, m_sr);
      chk1("in_ready", in_ready, m_ir);
      chk1("dbg_state", o_dbg_state[0], m_cnt != 0);
      if (flush) begin
        exp_q.delete();
        m_cnt = 0;
      end else if (seed_valid && m_sr) begin
        m_ra = (seed_a == 64'd0) ? RA_RST : seed_a;
        m_rb = (seed_b == 64'd0) ? RB_RST : seed_b;
      end else begin
        if (m_ov && out_ready) void'(exp_q.pop_front());
        if (in_valid && m_ir) begin
          exp_q.push_back({in_data, 3'(m_cnt), (m_cnt == WORDS - 1),
                           in_data ^ m_ra ^ m_rb, m_ra, m_rb});
          m_ra  = xs(m_ra);
          m_rb  = xs(m_rb);
          m_cnt = (m_cnt + 1) % WORDS;
        end
      end
    end
  end

  // driver tasks: each starts and ends one time unit after a rising edge
  task automatic put(input logic [63:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk1("put_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_seed();
    int n;
    n = 0;
    @(negedge clk);
    while (!seed_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk1("seed_timeout", seed_ready, 1'b1);
    @(posedge clk); #1;
    seed_valid = 1'b0;
  endtask

  task automatic do_seed(input logic [63:0] a, input logic [63:0] b);
    seed_valid = 1'b1;
    seed_a     = a;
    seed_b     = b;
    wait_seed();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [63:0] r_rand;

  initial begin
    rst_n = 1'b0; seed_valid = 1'b0; seed_a = '0; seed_b = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // first cycle after reset release
    @(negedge clk);
    chk1("post_rst_seed_ready", seed_ready, 1'b1);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    tick();

    // known vectors with seed a=1, b=2
    do_seed(64'h1, 64'h2);
    put(64'hFF);
    in_valid = 1'b0;
    @(negedge clk);
    chk64("kv0_s1", out_s1, 64'h1);
    chk64("kv0_s2", out_s2, 64'h2);
    chk64("kv0_s0", out_s0, 64'hFC);
    tick();
    out_ready = 1'b0;
    put(64'h0);
    in_valid = 1'b0;
    @(negedge clk);
    chk64("kv1_s1", out_s1, 64'h40822041);
    chk64("kv1_s2", out_s2, 64'h81044082);
    chk64("kv1_s0", out_s0, 64'hC18660C3);
    chk64("kv1_idx", 64'(out_idx), 64'd1);
    tick();

    // flush with word idx 1 pending
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("flush_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    put({$urandom, $urandom});
    in_valid = 1'b0;
    @(negedge clk);
    chk64("flush_idx", 64'(out_idx), 64'd0);
    chk64("flush_s1_cont", out_s1, xs(xs(64'h1)));
    chk64("flush_s2_cont", out_s2, xs(xs(64'h2)));
    tick();

    // finish the frame, then a 5-word back-to-back burst
    repeat (4) put({$urandom, $urandom});
    repeat (5) put({$urandom, $urandom});
    in_valid = 1'b0;
    tick();

    // backpressure: held output, in_ready low for 10 cycles
    out_ready = 1'b0;
    put({$urandom, $urandom});
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_in_ready", in_ready, 1'b1);
    tick();

    // seed request mid-frame waits for the frame to drain
    put({$urandom, $urandom});
    in_valid = 1'b0;
    r_rand = {$urandom, $urandom} | 64'h1;
    seed_valid = 1'b1;
    seed_a = 64'd0;
    seed_b = r_rand;
    @(negedge clk);
    chk1("seed_blocked", seed_ready, 1'b0);
    tick();
    repeat (3) put({$urandom, $urandom});
    in_valid = 1'b0;
    wait_seed();
    put({$urandom, $urandom});
    in_valid = 1'b0;
    @(negedge clk);
    chk64("seed0_s1", out_s1, RA_RST);
    chk64("seed_s2", out_s2, r_rand);
    chk64("seed_idx", 64'(out_idx), 64'd0);
    tick();

    // reset asserted mid-frame with an output pending
    repeat (2) put({$urandom, $urandom});
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_out_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    put({$urandom, $urandom});
    in_valid = 1'b0;
    @(negedge clk);
    chk64("rst_mid_idx", 64'(out_idx), 64'd0);
    chk64("rst_mid_s1", out_s1, RA_RST);
    chk64("rst_mid_s2", out_s2, RB_RST);
    tick();

    // zero seed for b only
    flush = 1'b1;
    tick();
    flush = 1'b0;
    r_rand = {$urandom, $urandom} | 64'h1;
    do_seed(r_rand, 64'd0);
    put({$urandom, $urandom});
    in_valid = 1'b0;
    @(negedge clk);
    chk64("seedb0_s1", out_s1, r_rand);
    chk64("seedb0_s2", out_s2, RB_RST);
    tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      seed_valid = ($urandom_range(0, 9) == 0);
      seed_a     = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      seed_b     = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; seed_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
